rcu_cb_model: RTL and testbench
===============================

# rcu_cb_model

Formal-verification model of the asynchronous side of RCU: the updater posts deferred-free callbacks (call_rcu style) instead of blocking, and a grace-period engine retires them once every reader that could hold the old version has left its critical section. It complements the synchronous grace-period updater model in the same safety suite. One process advances per clock, chosen by a free scheduler input. The block exports the state that the safety properties reference.

## Interface
- NRDR, 4, number of reader processes
- QDEPTH, 4, callback queue depth (power of two)
- PASSES, 10, maximum number of posts and maximum number of reader entries
- SELMSB, 2, select MSB; must satisfy 2^(SELMSB+1) >= NRDR+2
- clock  in  1  sole clock, posedge
- reset_n  in  1  asynchronous, active-low reset
- select  in  SELMSB+1  nondeterministic scheduler:
  - 0..NRDR-1 selects a reader.
  - NRDR selects the poster.
  - NRDR+1 selects the GP engine.
  - Any other value is an idle cycle.
- gp_seq_o  out  8  current grace-period number
- freed_o  out  8  highest freed object version
- cur_ver_o  out  8  current published version
- qcount_o  out  $clog2(QDEPTH)+1  queued callbacks
- err_o  out  1  sticky use-after-free flag

## Operation
- Reset (asynchronous, reset_n low):
  - All outputs are 0.
  - cur_ver is 1.
  - Queue is empty.
  - All pcs are in state 0.
  - rd_in, qs_pend, post_cnt and ent_cnt are 0.
- A process acts only on a cycle where it is selected. All others hold.
- Reader i, states R_IDLE → R_READ → R_EXIT:
  - R_IDLE: if ent_cnt < PASSES: set rd_in[i]=1, lcl_ver[i]=cur_ver, ent_cnt++, go to R_READ.
  - R_READ: if lcl_ver[i] <= freed, set err=1. Go to R_EXIT.
  - R_EXIT: clear rd_in[i] and qs_pend[i], go to R_IDLE.
- Poster, states P_IDLE → P_POST:
  - P_IDLE: if post_cnt < PASSES and the queue is not full, go to P_POST. Otherwise hold.
  - P_POST: enqueue {tag=gp_seq, ver=cur_ver}, then cur_ver++, post_cnt++, go to P_IDLE.
- GP engine, states G_IDLE → G_START → G_WAIT → G_INVOKE:
  - G_IDLE: if the queue is non-empty, go to G_START.
  - G_START: gp_seq++, qs_pend = rd_in, go to G_WAIT.
  - G_WAIT: if qs_pend == 0, go to G_INVOKE. Otherwise hold.
  - G_INVOKE:
    - If the queue is non-empty and head.tag < gp_seq: pop, set freed = head.ver, stay in G_INVOKE.
    - Otherwise go to G_IDLE.
    - At most one pop per selected cycle.
- Widths and wrap:
  - All 8-bit counters are bounded by PASSES <= 100, so no wrap occurs.
  - The comparisons are unsigned.
- Queue boundaries:
  - Full: the poster stalls in P_IDLE.
  - Empty: G_IDLE and G_INVOKE do not pop.
  - Pointers wrap modulo QDEPTH.
- Simultaneous events:
  - Only one process is selected per cycle, so push and pop never coincide.
  - The single-port queue behaviour is sufficient.
- Reset mid-operation returns every process to its initial state immediately. Queued callbacks are discarded.
- Properties required in the model:
  - Safety: !err_o.
  - freed_o < cur_ver_o.
  - qcount_o <= QDEPTH.
  - A reader in R_READ whose lcl_ver <= freed never occurs.

## Timing
- Every state transition takes one selected cycle. Outputs are registered.
- Minimum post-to-free latency is 5 selected cycles (P_POST, G_IDLE, G_START, G_WAIT, G_INVOKE), counting G_IDLE→G_START only after the enqueue. This holds when no reader is inside a critical section.
- A reader clears qs_pend in the R_EXIT cycle. G_WAIT sees the cleared bit on its next selection.

## Structure
- rcu_pkg holds the R_*, P_*, G_* state encodings and the 8-bit version/sequence width constant.
- One sub-module, rcu_cb_fifo: a QDEPTH-entry queue of {tag[7:0], ver[7:0]}.
  - Ports: push, pop, head, count, full, empty.
  - Reset: asynchronous, active-low.

## Test plan
- Reset, then poster only (select=4) ×2 → qcount_o=1, cur_ver_o=2, tag=0.
- Queue 1 callback; GP steps (select=5) ×5, no readers → gp_seq_o=1, freed_o=1, qcount_o=0.
- Reader 0 enters (select=0); post; GP to G_WAIT; GP ×3 → freed_o stays 0. Reader 0 steps twice → qs cleared; GP ×2 → freed_o=1, err_o=0.
- Callback posted while the GP is in G_WAIT (tag=1) → not popped in that G_INVOKE. It is freed only after a second GP.
- Post 4 with no GP → qcount_o=4; a further post selection stalls. cur_ver_o=5.
- Assert reset_n low while G_WAIT holds with a reader inside → all outputs 0 asynchronously, cur_ver_o=1 after release.

Source files
------------

// File: rtl/rcu_pkg.sv
// rcu_pkg: shared state encodings and widths for the call_rcu callback model
package rcu_pkg;
    localparam int VW = 8;

    typedef enum logic [1:0] {R_IDLE, R_READ, R_EXIT} rd_state_t;
    typedef enum logic {P_IDLE, P_POST} post_state_t;
    typedef enum logic [1:0] {G_IDLE, G_START, G_WAIT, G_INVOKE} gp_state_t;

    typedef struct packed {
        logic [VW-1:0] tag;
        logic [VW-1:0] ver;
    } cb_t;
endpackage

// File: rtl/rcu_cb_fifo.sv
// rcu_cb_fifo: QDEPTH-entry queue of deferred-free callbacks {tag, ver}
module rcu_cb_fifo import rcu_pkg::*; #(
    parameter int QDEPTH = 4,
    localparam int AW = $clog2(QDEPTH)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        push,
    input  cb_t         din,
    input  logic        pop,
    output cb_t         head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

    cb_t           mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];

    // storage needs no reset: only entries below count are ever observed
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;

    // pointers wrap naturally because QDEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/rcu_cb_model.sv
// rcu_cb_model: scheduler-driven model of call_rcu posting and grace-period callback retirement
module rcu_cb_model import rcu_pkg::*; #(
    parameter int NRDR   = 4,
    parameter int QDEPTH = 4,
    parameter int PASSES = 10,
    parameter int SELMSB = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [SELMSB:0]          select,
    output logic [7:0]               gp_seq_o,
    output logic [7:0]               freed_o,
    output logic [7:0]               cur_ver_o,
    output logic [$clog2(QDEPTH):0]  qcount_o,
    output logic                     err_o
);
    localparam logic [SELMSB:0] SEL_POST = (SELMSB+1)'(NRDR);
    localparam logic [SELMSB:0] SEL_GP   = (SELMSB+1)'(NRDR + 1);
    localparam logic [VW-1:0]   PASS_MAX = VW'(PASSES);
    localparam logic [$clog2(QDEPTH):0] QMAX = ($clog2(QDEPTH)+1)'(QDEPTH);

    rd_state_t   rd_state   [NRDR];
    rd_state_t   rd_state_n [NRDR];
    logic [VW-1:0] lcl_ver   [NRDR];
    logic [VW-1:0] lcl_ver_n [NRDR];
    logic [NRDR-1:0] rd_in, rd_in_n, qs_pend, qs_pend_n;
    logic [VW-1:0] ent_cnt, ent_cnt_n, post_cnt, post_cnt_n;
    logic [VW-1:0] gp_seq, gp_seq_n, freed, freed_n, cur_ver, cur_ver_n;
    logic          err, err_n;
    post_state_t   p_state, p_state_n;
    gp_state_t     g_state, g_state_n;
    logic          push, pop, full, empty;
    cb_t           push_cb, head;

    assign push_cb = '{tag: gp_seq, ver: cur_ver};

    rcu_cb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_cb),
        .pop     (pop),
        .head    (head),
        .count   (qcount_o),
        .full    (full),
        .empty   (empty)
    );

    // the selected process computes its next state; every other process holds
    always_comb begin
        rd_state_n = rd_state;
        lcl_ver_n  = lcl_ver;
        rd_in_n    = rd_in;
        qs_pend_n  = qs_pend;
        ent_cnt_n  = ent_cnt;
        err_n      = err;
        p_state_n  = p_state;
        post_cnt_n = post_cnt;
        cur_ver_n  = cur_ver;
        push       = 1'b0;
        g_state_n  = g_state;
        gp_seq_n   = gp_seq;
        freed_n    = freed;
        pop        = 1'b0;
        for (int i = 0; i < NRDR; i++) begin
            if (select == (SELMSB+1)'(i)) begin
                case (rd_state[i])
                    R_IDLE: if (ent_cnt < PASS_MAX) begin
                        rd_in_n[i]    = 1'b1;
                        lcl_ver_n[i]  = cur_ver;
                        ent_cnt_n     = ent_cnt + 1'b1;
                        rd_state_n[i] = R_READ;
                    end
                    R_READ: begin
                        if (lcl_ver[i] <= freed) err_n = 1'b1;
                        rd_state_n[i] = R_EXIT;
                    end
                    default: begin
                        rd_in_n[i]    = 1'b0;
                        qs_pend_n[i]  = 1'b0;
                        rd_state_n[i] = R_IDLE;
                    end
                endcase
            end
        end
        if (select == SEL_POST) begin
            case (p_state)
                P_IDLE: p_state_n = (post_cnt < PASS_MAX && !full) ? P_POST : P_IDLE;
                default: begin
                    push       = 1'b1;
                    cur_ver_n  = cur_ver + 1'b1;
                    post_cnt_n = post_cnt + 1'b1;
                    p_state_n  = P_IDLE;
                end
            endcase
        end
        if (select == SEL_GP) begin
            case (g_state)
                G_IDLE:  g_state_n = empty ? G_IDLE : G_START;
                G_START: begin
                    gp_seq_n  = gp_seq + 1'b1;
                    qs_pend_n = rd_in;
                    g_state_n = G_WAIT;
                end
                G_WAIT:  g_state_n = (qs_pend == '0) ? G_INVOKE : G_WAIT;
                default: begin
                    if (!empty && head.tag < gp_seq) begin
                        pop     = 1'b1;
                        freed_n = head.ver;
                    end else begin
                        g_state_n = G_IDLE;
                    end
                end
            endcase
        end
    end

    // all process state registers; reset abandons any in-flight work
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NRDR; i++) begin
                rd_state[i] <= R_IDLE;
                lcl_ver[i]  <= '0;
            end
            rd_in    <= '0;
            qs_pend  <= '0;
            ent_cnt  <= '0;
            err      <= 1'b0;
            p_state  <= P_IDLE;
            post_cnt <= '0;
            cur_ver  <= VW'(1);
            g_state  <= G_IDLE;
            gp_seq   <= '0;
            freed    <= '0;
        end else begin
            rd_state <= rd_state_n;
            lcl_ver  <= lcl_ver_n;
            rd_in    <= rd_in_n;
            qs_pend  <= qs_pend_n;
            ent_cnt  <= ent_cnt_n;
            err      <= err_n;
            p_state  <= p_state_n;
            post_cnt <= post_cnt_n;
            cur_ver  <= cur_ver_n;
            g_state  <= g_state_n;
            gp_seq   <= gp_seq_n;
            freed    <= freed_n;
        end

    assign gp_seq_o  = gp_seq;
    assign freed_o   = freed;
    assign cur_ver_o = reset_n ? cur_ver : '0;
    assign err_o     = err;

    ap_no_err: assert property (@(posedge clock) disable iff (!reset_n) !err_o);
    ap_freed_lt_cur: assert property (@(posedge clock) disable iff (!reset_n) freed_o < cur_ver_o);
    ap_qcount_bound: assert property (@(posedge clock) disable iff (!reset_n) qcount_o <= QMAX);

    for (genvar g = 0; g < NRDR; g++) begin : g_rd_safe
        ap_no_stale_read: assert property (@(posedge clock) disable iff (!reset_n)
            !(rd_state[g] == R_READ && lcl_ver[g] <= freed));
    end
endmodule

// File: tb/tb_rcu_cb_model.sv
// tb_rcu_cb_model: directed scenarios for call_rcu posting and grace-period retirement
module tb_rcu_cb_model;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] select = 3'd7;
    logic [7:0] gp_seq_o, freed_o, cur_ver_o;
    logic [2:0] qcount_o;
    logic       err_o;
    int         n_checks = 0;
    int         n_fail = 0;

    rcu_cb_model #(.NRDR(4), .QDEPTH(4), .PASSES(10), .SELMSB(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .select    (select),
        .gp_seq_o  (gp_seq_o),
        .freed_o   (freed_o),
        .cur_ver_o (cur_ver_o),
        .qcount_o  (qcount_o),
        .err_o     (err_o)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        select  = 3'd7;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic [2:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            select = s;
            @(posedge clock);
            #1;
            select = 3'd7;
        end
    endtask

    task automatic test_reset();
        select  = 3'd7;
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({gp_seq_o, freed_o, cur_ver_o, qcount_o, err_o} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gp=%0d freed=%0d cur=%0d q=%0d err=%0b, want all 0",
                     gp_seq_o, freed_o, cur_ver_o, qcount_o, err_o);
        end
        apply_reset();
        step(3'd6, 1);
        step(3'd7, 1);
        n_checks++;
        if (cur_ver_o !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_cur_ver: got %0d want 1", cur_ver_o);
        end
        n_checks++;
        if (qcount_o !== 3'd0 || gp_seq_o !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got q=%0d gp=%0d want 0 0", qcount_o, gp_seq_o);
        end
    endtask

    task automatic test_post();
        apply_reset();
        step(3'd4, 1);
        n_checks++;
        if (qcount_o !== 3'd0 || cur_ver_o !== 8'd1) begin
            n_fail++;
            $display("FAIL post_first_step: got q=%0d cur=%0d want 0 1", qcount_o, cur_ver_o);
        end
        step(3'd4, 1);
        n_checks++;
        if (qcount_o !== 3'd1 || cur_ver_o !== 8'd2) begin
            n_fail++;
            $display("FAIL post_enqueue: got q=%0d cur=%0d want 1 2", qcount_o, cur_ver_o);
        end
    endtask

    task automatic test_gp_no_reader();
        apply_reset();
        step(3'd4, 2);
        step(3'd5, 3);
        n_checks++;
        if (freed_o !== 8'd0 || gp_seq_o !== 8'd1) begin
            n_fail++;
            $display("FAIL gp_before_invoke: got freed=%0d gp=%0d want 0 1", freed_o, gp_seq_o);
        end
        step(3'd5, 2);
        n_checks++;
        if (gp_seq_o !== 8'd1 || freed_o !== 8'd1 || qcount_o !== 3'd0) begin
            n_fail++;
            $display("FAIL gp_free: got gp=%0d freed=%0d q=%0d want 1 1 0", gp_seq_o, freed_o, qcount_o);
        end
    endtask

    task automatic test_reader_blocks_gp();
        apply_reset();
        step(3'd0, 1);
        step(3'd4, 2);
        step(3'd5, 2);
        step(3'd5, 3);
        n_checks++;
        if (freed_o !== 8'd0 || qcount_o !== 3'd1) begin
            n_fail++;
            $display("FAIL reader_blocks: got freed=%0d q=%0d want 0 1", freed_o, qcount_o);
        end
        step(3'd0, 2);
        step(3'd5, 2);
        n_checks++;
        if (freed_o !== 8'd1 || err_o !== 1'b0 || qcount_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reader_release: got freed=%0d err=%0b q=%0d want 1 0 0", freed_o, err_o, qcount_o);
        end
    endtask

    task automatic test_late_post();
        apply_reset();
        step(3'd4, 2);
        step(3'd5, 2);
        step(3'd4, 2);
        step(3'd5, 3);
        n_checks++;
        if (freed_o !== 8'd1 || qcount_o !== 3'd1 || gp_seq_o !== 8'd1) begin
            n_fail++;
            $display("FAIL late_post_held: got freed=%0d q=%0d gp=%0d want 1 1 1", freed_o, qcount_o, gp_seq_o);
        end
        step(3'd5, 4);
        n_checks++;
        if (freed_o !== 8'd2 || qcount_o !== 3'd0 || gp_seq_o !== 8'd2) begin
            n_fail++;
            $display("FAIL late_post_second_gp: got freed=%0d q=%0d gp=%0d want 2 0 2", freed_o, qcount_o, gp_seq_o);
        end
    endtask

    task automatic test_queue_full();
        apply_reset();
        step(3'd4, 8);
        n_checks++;
        if (qcount_o !== 3'd4 || cur_ver_o !== 8'd5) begin
            n_fail++;
            $display("FAIL queue_fill: got q=%0d cur=%0d want 4 5", qcount_o, cur_ver_o);
        end
        step(3'd4, 3);
        n_checks++;
        if (qcount_o !== 3'd4 || cur_ver_o !== 8'd5) begin
            n_fail++;
            $display("FAIL queue_stall: got q=%0d cur=%0d want 4 5", qcount_o, cur_ver_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(3'd0, 1);
        step(3'd4, 2);
        step(3'd5, 3);
        n_checks++;
        if (gp_seq_o !== 8'd1 || qcount_o !== 3'd1 || cur_ver_o !== 8'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: got gp=%0d q=%0d cur=%0d want 1 1 2", gp_seq_o, qcount_o, cur_ver_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({gp_seq_o, freed_o, cur_ver_o, qcount_o, err_o} !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gp=%0d freed=%0d cur=%0d q=%0d err=%0b, want all 0",
                     gp_seq_o, freed_o, cur_ver_o, qcount_o, err_o);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (cur_ver_o !== 8'd1 || qcount_o !== 3'd0) begin
            n_fail++;
            $display("FAIL after_release: got cur=%0d q=%0d want 1 0", cur_ver_o, qcount_o);
        end
        step(3'd4, 2);
        step(3'd5, 4);
        n_checks++;
        if (freed_o !== 8'd1 || gp_seq_o !== 8'd1 || qcount_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reader_discarded: got freed=%0d gp=%0d q=%0d want 1 1 0", freed_o, gp_seq_o, qcount_o);
        end
    endtask

    initial begin
        test_reset();
        test_post();
        test_gp_no_reader();
        test_reader_blocks_gp();
        test_late_post();
        test_queue_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
